// File: rtl/m_decode_pkg.sv
// Constants shared by the decode stage and its packet buffer.
package m_decode_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] ILLEGAL_ZERO = '0;

    // Instruction word as carried in a fetch packet lane.
    typedef logic [INSTR_W-1:0] s_instr;

endpackage

// File: rtl/m_decoder_pkg.sv
// Types shared by the RV32 base decoder and the stages that consume its output.
package m_decoder_pkg;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        unknown;   // opcode is not an RV32I base opcode
    } s_decoded;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/m_decoder.sv
// Combinational RV32I field extractor and immediate generator.
module m_decoder
    import m_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output s_decoded    dec
);

    // Raw fields always extracted; immediate and unknown flag chosen by opcode.
    always_comb begin
        dec         = '0;
        dec.opcode  = instr[6:0];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct7  = instr[31:25];
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:
                dec.imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec.imm = {instr[31:12], 12'h000};
            OP_JAL:
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_REG:
                dec.imm = '0;
            default:
                dec.unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/m_packet_fifo.sv
// Synchronous packet FIFO; head is registered storage only (no fall-through).
module m_packet_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("m_packet_fifo: DEPTH must be a power of two >= 2");
    end

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage write; caller guarantees push only when not full.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/m_decode_stage.sv
// Decode stage: buffers fetch packets and emits one decoded instruction per cycle.
module m_decode_stage
    import m_decode_pkg::*;
    import m_decoder_pkg::*;
#(
    parameter int  XLEN  = 32,
    parameter int  LANES = 2,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [INSTR_W*LANES-1:0] in_instr,
    input  logic [LANES-1:0]         in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output s_decoded                 out_decoded,
    output logic                     out_illegal,
    output logic [CW-1:0]            count
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_chk
        $error("m_decode_stage: LANES must be 1, 2 or 4");
    end

    typedef struct packed {
        logic [XLEN-1:0]         pc;
        logic [LANES-1:0][INSTR_W-1:0] instr;
        logic [LANES-1:0]        mask;
    } s_fetch_packet;

    s_fetch_packet    pkt_in;
    s_fetch_packet    head;
    logic [CW-1:0]    fifo_cnt;
    logic             push;
    logic             pop_head;
    logic             fire;

    // rem_vld=0 means the head entry is fresh and its own mask is the remaining set;
    // this lets the next packet start emitting in the same edge the head pops.
    logic [LANES-1:0] rem;
    logic             rem_vld;
    logic [LANES-1:0] eff;
    logic [LANES-1:0] clr;
    logic [LW-1:0]    lane;
    s_instr           sel_instr;

    assign pkt_in   = '{pc: in_pc, instr: in_instr, mask: in_mask};
    assign in_ready = rst_n && (fifo_cnt != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush && (|in_mask);
    assign out_valid = rst_n && (fifo_cnt != '0);
    assign count    = rst_n ? fifo_cnt : '0;
    assign fire     = out_valid && out_ready;
    assign eff      = rem_vld ? rem : head.mask;
    assign pop_head = fire && ((eff & ~clr) == '0);

    m_packet_fifo #(
        .T     (s_fetch_packet),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (pkt_in),
        .pop   (pop_head),
        .head  (head),
        .count (fifo_cnt)
    );

    // Lowest remaining lane; iterate high to low so the lowest set bit wins.
    always_comb begin
        lane = '0;
        clr  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (eff[i]) lane = LW'(i);
        end
        clr[lane] = 1'b1;
    end

    // Track lanes still to emit from the head entry.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rem     <= '0;
            rem_vld <= 1'b0;
        end else if (fire) begin
            if (pop_head) begin
                rem_vld <= 1'b0;
            end else begin
                rem     <= eff & ~clr;
                rem_vld <= 1'b1;
            end
        end
    end

    assign sel_instr = head.instr[lane];
    assign out_pc    = head.pc + (XLEN'(lane) << 2);

    m_decoder u_dec (
        .instr (sel_instr),
        .dec   (out_decoded)
    );

    // Compressed encodings and the all-zero word are not supported.
    assign out_illegal = (sel_instr[1:0] != 2'b11) || (sel_instr == ILLEGAL_ZERO)
                         || out_decoded.unknown;

endmodule

// File: tb/tb_m_decode_stage.sv
// Directed, table-driven bench for m_decode_stage (LANES=2, DEPTH=4).
module tb_m_decode_stage;
    import m_decoder_pkg::*;

    localparam logic [31:0] I_ADDI0 = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [31:0] I_ADDI1 = 32'h0010_0093;   // addi x1,x0,1

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_pc, out_pc;
    logic [63:0] in_instr;
    logic [1:0]  in_mask;
    logic [2:0]  count;
    s_decoded    out_decoded;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    m_decode_stage #(.XLEN(32), .LANES(2), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_mask     (in_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_decoded (out_decoded),
        .out_illegal (out_illegal),
        .count       (count)
    );

    typedef struct {
        logic        rst_n, flush, iv;
        logic [31:0] pc, i0, i1;
        logic [1:0]  mask;
        logic        ordy;
        logic        e_ir, e_ov;
        int          e_cnt;
        logic [31:0] e_pc;
        logic        e_ill;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] m,
                       input logic ordy, input logic eir, input logic eov, input int ecnt,
                       input logic [31:0] epc, input logic eill, input logic [4:0] erd);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.pc = pc; v.i0 = i0; v.i1 = i1; v.mask = m;
        v.ordy = ordy; v.e_ir = eir; v.e_ov = eov; v.e_cnt = ecnt; v.e_pc = epc;
        v.e_ill = eill; v.e_rd = erd;
        tv.push_back(v);
    endtask

    // Idle cycle with no input packet.
    task automatic idle(input logic ordy, input logic eov, input int ecnt,
                        input logic [31:0] epc, input logic eill, input logic [4:0] erd);
        add(1, 0, 0, 0, 0, 0, 0, ordy, 1'b1, eov, ecnt, epc, eill, erd);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n     = v.rst_n;
        flush     = v.flush;
        in_valid  = v.iv;
        in_pc     = v.pc;
        in_instr  = {v.i1, v.i0};
        in_mask   = v.mask;
        out_ready = v.ordy;
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_pc = 0; in_instr = 0; in_mask = 0; out_ready = 0;

        // reset, with a packet offered that must be ignored
        add(0, 0, 1, 32'h1000, I_ADDI0, I_ADDI1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 32'h1000, I_ADDI0, I_ADDI1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
        // two-lane packet, out_ready held high
        add(1, 0, 1, 32'h1000, I_ADDI0, I_ADDI1, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        idle(1, 1, 1, 32'h1000, 0, 5'd0);
        idle(1, 1, 1, 32'h1004, 0, 5'd1);
        idle(1, 0, 0, 0, 0, 0);
        // lane 1 only, then an empty-mask packet that must be dropped
        add(1, 0, 1, 32'h2000, 32'h0, I_ADDI1, 2'b10, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 32'h3000, I_ADDI0, I_ADDI1, 2'b00, 1, 1, 1, 1, 32'h2004, 0, 5'd1);
        idle(1, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        // illegal encodings are still emitted
        add(1, 0, 1, 32'h4000, 32'h0, 32'h0000_4501, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        idle(1, 1, 1, 32'h4000, 1, 5'd0);
        idle(1, 1, 1, 32'h4004, 1, 5'd10);
        idle(1, 0, 0, 0, 0, 0);
        // PC wraps at the top of the address space
        add(1, 0, 1, 32'hFFFF_FFFC, I_ADDI0, I_ADDI1, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        idle(1, 1, 1, 32'hFFFF_FFFC, 0, 5'd0);
        idle(1, 1, 1, 32'h0000_0000, 0, 5'd1);
        idle(1, 0, 0, 0, 0, 0);
        // stall on lane 1 for three cycles
        add(1, 0, 1, 32'h6000, I_ADDI0, I_ADDI1, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        idle(1, 1, 1, 32'h6000, 0, 5'd0);
        idle(0, 1, 1, 32'h6004, 0, 5'd1);
        idle(0, 1, 1, 32'h6004, 0, 5'd1);
        idle(0, 1, 1, 32'h6004, 0, 5'd1);
        idle(1, 1, 1, 32'h6004, 0, 5'd1);
        idle(1, 0, 0, 0, 0, 0);
        // flush with three entries, lane 1 pending, and a new packet offered
        add(1, 0, 1, 32'h7000, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 32'h7010, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 1, 1, 32'h7000, 0, 5'd0);
        add(1, 0, 1, 32'h7020, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 1, 2, 32'h7000, 0, 5'd0);
        idle(1, 1, 3, 32'h7000, 0, 5'd0);
        add(1, 1, 1, 32'h7030, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 1, 3, 32'h7004, 0, 5'd1);
        idle(1, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        // reset mid-operation behaves the same, with in_ready low during reset
        add(1, 0, 1, 32'h8000, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 32'h8010, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 1, 1, 32'h8000, 0, 5'd0);
        add(1, 0, 1, 32'h8020, I_ADDI0, I_ADDI1, 2'b11, 0, 1, 1, 2, 32'h8000, 0, 5'd0);
        idle(1, 1, 3, 32'h8000, 0, 5'd0);
        add(0, 0, 1, 32'h8030, I_ADDI0, I_ADDI1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);

        foreach (tv[r]) begin
            @(negedge clk);
            drive(tv[r]);
            #1;
            chk("in_ready", r, 32'(in_ready), 32'(tv[r].e_ir));
            chk("out_valid", r, 32'(out_valid), 32'(tv[r].e_ov));
            chk("count", r, 32'(count), tv[r].e_cnt);
            if (tv[r].e_ov) begin
                chk("out_pc", r, out_pc, tv[r].e_pc);
                chk("out_illegal", r, 32'(out_illegal), 32'(tv[r].e_ill));
                chk("rd", r, 32'(out_decoded.rd), 32'(tv[r].e_rd));
            end
        end

        // fill with out_ready low: five offered, four accepted
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst_n = 1; flush = 0; out_ready = 0; in_valid = 1;
            in_pc = 32'h5000 + 32'(16 * k); in_instr = {I_ADDI1, I_ADDI0}; in_mask = 2'b11;
            #1;
            chk("fill_in_ready", 100 + k, 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
            chk("fill_count", 100 + k, 32'(count), 32'(k));
        end
        // drain: eight instructions on eight consecutive cycles
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            in_valid = 0; out_ready = 1;
            #1;
            chk("drain_valid", 200 + j, 32'(out_valid), 32'd1);
            chk("drain_pc", 200 + j, out_pc, 32'h5000 + 32'(16 * (j / 2)) + 32'(4 * (j % 2)));
            chk("drain_count", 200 + j, 32'(count), 32'(4 - j / 2));
            chk("drain_in_ready", 200 + j, 32'(in_ready), (j >= 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        chk("drain_empty", 300, 32'(out_valid), 32'd0);
        chk("drain_count0", 300, 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m_decode_stage.md
Name: m_decode_stage

Overview:
- Parametrised decode stage between fetch and issue.
- Accepts fetch packets of LANES 32-bit instructions with a per-lane valid mask, buffers up to DEPTH packets, and serialises them.
- Decodes one instruction per cycle through the existing m_decoder, with valid/ready handshakes on both sides, flush, and illegal-instruction flagging.

Parameters:
- XLEN, 32, PC width.
- LANES, 2, instructions per fetch packet; allowed values 1, 2, 4.
- DEPTH, 4, packet buffer entries; power of two, >=2; elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered and in-flight work.
- in_valid  in  1  fetch packet present.
- in_ready  out  1  stage can accept a packet.
- in_pc  in  XLEN  PC of lane 0.
- in_instr  in  32*LANES  lane i at bits [32*i+31:32*i].
- in_mask  in  LANES  lane i valid.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  consumer accepts.
- out_pc  out  XLEN  PC of emitted instruction.
- out_decoded  out  s_decoded  m_decoder output for emitted instruction.
- out_illegal  out  1  emitted instruction illegal.
- count  out  $clog2(DEPTH)+1  occupied packet entries.

Behaviour:
- Reset: on a clk edge with rst_n=0, the FIFO is emptied and the pointers and lane-remaining mask are cleared. While rst_n=0: in_ready=0, out_valid=0, count=0. After reset releases: in_ready=1.
- Accept: a packet is accepted on an edge with in_valid&&in_ready&&!flush.
  - in_mask==0 packets are accepted but not written (dropped).
  - Otherwise {in_pc, in_instr, in_mask} is written at the write pointer.
- in_ready = rst_n && (count<DEPTH). It has no combinational path from out_ready, so a full buffer stalls for one cycle even if a pop occurs that cycle.
- Latency: a packet accepted at edge t can appear on out_valid from cycle t+1. There is no fall-through path.
- Serialiser:
  - Register rem_mask holds the lanes not yet emitted from the head entry. It loads from the head mask when the head becomes valid.
  - Emitted lane L = lowest set bit of rem_mask.
  - out_valid = (count!=0).
  - out_pc = head_pc + 4*L, truncated to XLEN (wraps).
  - out_decoded = m_decoder(head_instr[L]), combinational from registered head state.
- Pop: on out_valid&&out_ready, clear bit L in rem_mask.
  - If that was the last set bit, pop the head and load rem_mask from the next entry's mask in the same edge, so back-to-back packets emit with no bubble.
- Outputs are stable while out_valid&&!out_ready.
- out_illegal=1 iff instr[1:0]!=2'b11 (compressed not supported) or instr==32'h0 or m_decoder flags an unknown opcode. Illegal instructions are still emitted normally; the downstream stage raises the trap.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- flush: highest priority after reset.
  - On an edge with flush=1: FIFO emptied, rem_mask cleared, any in_valid packet that cycle ignored, any out handshake that cycle still counts as consumed.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-packet behaves as flush, plus the outputs are forced low during reset.

Decomposition:
- Shared decode package:
  - s_fetch_packet typedef {pc, instr[LANES], mask}.
  - INSTR_W=32 and ILLEGAL_ZERO constants.
  - s_decoded stays in the existing decoder package.
- m_decoder instantiated unchanged, single instance after the lane mux.
- One natural sub-module: m_packet_fifo, a parametrised synchronous FIFO of s_fetch_packet with push/pop/flush/count and no fall-through.

Test Plan:
- LANES=2, reset, one packet pc=0x1000, mask=2'b11, instrs 0x00000013 and 0x00100093, out_ready=1. Expected: outputs at cycles t+1 and t+2 with pc 0x1000 then 0x1004, both out_illegal=0, count back to 0.
- mask=2'b10, pc=0x2000. Expected: exactly one output, pc=0x2004. A following packet with mask=2'b00 produces no output and count never increments.
- DEPTH=4, out_ready=0, 5 packets offered. Expected: 4 accepted, in_ready=0 with count=4. Raise out_ready: 8 instructions drain in 8 consecutive cycles with no bubble between packets, and in_ready reasserts the cycle after the first pop.
- Stall mid-packet: out_ready=0 for 3 cycles on lane 1. Expected: out_pc/out_decoded held constant. Lane 0 is not re-emitted.
- Flush while count=3 and lane 1 pending, with a new in_valid in the same cycle. Expected: next cycle out_valid=0, count=0, and the new packet is absent. Reset mid-operation gives the same result, and in_ready=0 while rst_n=0.
- Illegal cases: lane instrs 0x00000000 and 0x00004501 (compressed). Expected: both emitted with out_illegal=1. pc=0xFFFFFFFC with mask=2'b11: second out_pc=0x00000000.
